zoom_cmd_sequencer: RTL

Sequences commands from the HPS to the zoom coprocessor datapath and exposes their progress as status. The HPS writes a command over an Avalon-MM slave. The block holds one command pending, issues it to the coprocessor with a start/busy/done handshake, and guards each run with a timeout. It reports busy/done/timeout/overflow through a status register, a level interrupt and a single `status_busy` bit that feeds the existing 1-bit status PIO.

---
 rtl/zoom_pkg.sv | 24 ++
 rtl/zoom_cmd_timer.sv | 27 ++
 rtl/zoom_cmd_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/zoom_pkg.sv
// Shared constants and types for the zoom coprocessor command sequencer.
package zoom_pkg;

  localparam int CMD_W = 8;

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_CMD     = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_TIMEOUT  = 2;
  localparam int STAT_PENDING  = 3;
  localparam int STAT_OVERFLOW = 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_RUN      = 2'd3
  } zoom_state_e;

endpackage

// File: rtl/zoom_cmd_timer.sv
// 16-bit load/decrement watchdog counter guarding one coprocessor run.
module zoom_cmd_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] load_val,
  output logic [15:0] value,
  output logic        expire
);

  // Count down while enabled; parks at 1 so a missed expiry re-fires next cycle, and 0 never expires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= 16'd0;
    end else if (load) begin
      value <= load_val;
    end else if (en && (value > 16'd1)) begin
      value <= value - 16'd1;
    end else begin
      value <= value;
    end
  end

  assign expire = en && (value == 16'd1);

endmodule

// File: rtl/zoom_cmd_sequencer.sv
// Avalon-MM command sequencer: one pending slot, start/busy/done handshake with the
// zoom coprocessor, timeout abort, sticky status, level interrupt and PIO busy bit.
module zoom_cmd_sequencer #(
  parameter int          CMD_W      = zoom_pkg::CMD_W,
  parameter logic [15:0] TO_DEFAULT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [CMD_W-1:0] cop_cmd,
  output logic             cop_start,
  output logic             cop_abort,
  input  logic             cop_busy,
  input  logic             cop_done,
  output logic             irq,
  output logic             status_busy
);
  import zoom_pkg::*;

  zoom_state_e      r_state;
  logic [CMD_W-1:0] r_slot;
  logic             r_pending;
  logic             r_done;
  logic             r_timeout;
  logic             r_overflow;
  logic             r_irq_en;
  logic [15:0]      r_timeout_val;

  logic        w_busy;
  logic        w_consume;
  logic        w_wr_status;
  logic        w_wr_cmd;
  logic        w_wr_ctrl;
  logic        w_wr_timeout;
  logic        w_cmd_accept;
  logic        w_set_overflow;
  logic        w_set_done;
  logic        w_set_timeout;
  logic        w_timer_load;
  logic        w_timer_en;
  logic        w_expire;
  logic [15:0] w_timer_value;
  logic        w_unused_ok;

  zoom_cmd_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_timer_load),
    .en       (w_timer_en),
    .load_val (r_timeout_val),
    .value    (w_timer_value),
    .expire   (w_expire)
  );

  // Decode bus writes and FSM events; a slot being consumed this edge counts as free.
  always_comb begin
    w_wr_status    = write && (address == ADDR_STATUS);
    w_wr_cmd       = write && (address == ADDR_CMD);
    w_wr_ctrl      = write && (address == ADDR_CTRL);
    w_wr_timeout   = write && (address == ADDR_TIMEOUT);
    w_consume      = (r_state == S_IDLE) && r_pending;
    w_cmd_accept   = w_wr_cmd && (!r_pending || w_consume);
    w_set_overflow = w_wr_cmd && r_pending && !w_consume;
    w_timer_load   = (r_state == S_ISSUE);
    w_timer_en     = (r_state == S_WAIT_ACK) || (r_state == S_RUN);
    w_set_done     = w_timer_en && cop_done;
    if (r_state == S_WAIT_ACK) begin
      w_set_timeout = !cop_done && !cop_busy && w_expire;
    end else if (r_state == S_RUN) begin
      w_set_timeout = !cop_done && w_expire;
    end else begin
      w_set_timeout = 1'b0;
    end
  end

  assign w_busy      = (r_state != S_IDLE) || r_pending;
  assign status_busy = w_busy;
  assign irq         = r_irq_en && (r_done || r_timeout || r_overflow);
  assign w_unused_ok = &{1'b0, writedata[31:16], w_timer_value};

  // Register file: pending slot, sticky status (set beats W1C), control and timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot        <= '0;
      r_pending     <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_overflow    <= 1'b0;
      r_irq_en      <= 1'b0;
      r_timeout_val <= TO_DEFAULT;
    end else begin
      if (w_cmd_accept) begin
        r_slot    <= writedata[CMD_W-1:0];
        r_pending <= 1'b1;
      end else if (w_consume) begin
        r_pending <= 1'b0;
      end else begin
        r_pending <= r_pending;
      end

      if (w_set_done) begin
        r_done <= 1'b1;
      end else if (w_wr_status && writedata[STAT_DONE]) begin
        r_done <= 1'b0;
      end else begin
        r_done <= r_done;
      end

      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end else if (w_wr_status && writedata[STAT_TIMEOUT]) begin
        r_timeout <= 1'b0;
      end else begin
        r_timeout <= r_timeout;
      end

      if (w_set_overflow) begin
        r_overflow <= 1'b1;
      end else if (w_wr_status && writedata[STAT_OVERFLOW]) begin
        r_overflow <= 1'b0;
      end else begin
        r_overflow <= r_overflow;
      end

      if (w_wr_ctrl) begin
        r_irq_en <= writedata[0];
      end else begin
        r_irq_en <= r_irq_en;
      end

      if (w_wr_timeout) begin
        r_timeout_val <= writedata[15:0];
      end else begin
        r_timeout_val <= r_timeout_val;
      end
    end
  end

  // Registered read mux, updated every clock from the address bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else begin
      case (address)
        ADDR_STATUS:  readdata <= {27'd0, r_overflow, r_pending, r_timeout, r_done, w_busy};
        ADDR_CMD:     readdata <= 32'd0;
        ADDR_CTRL:    readdata <= {31'd0, r_irq_en};
        ADDR_TIMEOUT: readdata <= {16'd0, r_timeout_val};
        default:      readdata <= 32'd0;
      endcase
    end
  end

  // Command FSM with registered start/abort pulses and command output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      cop_cmd   <= '0;
      cop_start <= 1'b0;
      cop_abort <= 1'b0;
    end else begin
      cop_start <= 1'b0;
      cop_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            cop_cmd   <= r_slot;
            cop_start <= 1'b1;
            r_state   <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (cop_done) begin
            r_state <= S_IDLE;
          end else if (cop_busy) begin
            r_state <= S_RUN;
          end else if (w_expire) begin
            cop_abort <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_state <= S_WAIT_ACK;
          end
        end
        S_RUN: begin
          if (cop_done) begin
            r_state <= S_IDLE;
          end else if (w_expire) begin
            cop_abort <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
